stall_controller: RTL and testbench

- Central hazard sequencer for the 5-stage pipeline.
- Drives Fetch's branch-stall, dependency-stall and branch-redirect inputs.
- Tracks in-flight register writes in a per-register scoreboard.
- Runs a branch-resolution FSM between decode issue and memory-stage resolve. Sits between Decode, Memory and Writeback, with outputs feeding Fetch and Decode.

---
 rtl/stall_controller.sv | 144 ++++++++++++++
 tb/tb_stall_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stall_controller.sv
// Hazard sequencer: per-register pending-write scoreboard plus a branch-resolve FSM. All state updates on the negedge of I_CLOCK.
// Dependency stall and issue are combinational. Branch stall, redirect strobe and target are registered.
module stall_controller #(
  parameter int NUM_REGS        = 16,
  parameter int REG_IDX_W       = 4,
  parameter int PC_WIDTH        = 16,
  parameter int CNT_W           = 2,
  parameter int RESOLVE_TIMEOUT = 8
) (
  input  logic                 I_CLOCK,
  input  logic                 I_LOCK,
  input  logic                 I_DE_Valid,
  input  logic                 I_DE_IsBranch,
  input  logic                 I_DE_Src1Valid,
  input  logic [REG_IDX_W-1:0] I_DE_Src1,
  input  logic                 I_DE_Src2Valid,
  input  logic [REG_IDX_W-1:0] I_DE_Src2,
  input  logic                 I_DE_DstValid,
  input  logic [REG_IDX_W-1:0] I_DE_Dst,
  input  logic                 I_WB_Valid,
  input  logic [REG_IDX_W-1:0] I_WB_Dst,
  input  logic                 I_MEM_BrResolve,
  input  logic                 I_MEM_BrTaken,
  input  logic [PC_WIDTH-1:0]  I_MEM_BrTarget,
  output logic                 O_DepStallSignal,
  output logic                 O_BranchStallSignal,
  output logic                 O_BranchAddrSelect,
  output logic [PC_WIDTH-1:0]  O_BranchPC,
  output logic                 O_Issue,
  output logic                 O_Error
);

  localparam int TMO_W = $clog2(RESOLVE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RESOLVE = 2'd1,
    REDIRECT     = 2'd2
  } br_state_e;

  br_state_e            state_q, state_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [CNT_W-1:0]     pend_q [NUM_REGS];
  logic [CNT_W-1:0]     pend_d [NUM_REGS];
  logic                 br_stall_q, br_stall_d;
  logic                 sel_q, sel_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic                 err_q, err_d;

  logic                 src1_haz, src2_haz, dst_full;
  logic                 dep_stall, issue;
  logic [NUM_REGS-1:0]  inc_vec, dec_vec;
  logic                 sb_err, fsm_err;

  always_comb begin
    src1_haz  = I_DE_Src1Valid && (pend_q[I_DE_Src1] != '0);
    src2_haz  = I_DE_Src2Valid && (pend_q[I_DE_Src2] != '0);
    dst_full  = I_DE_DstValid && (pend_q[I_DE_Dst] == CNT_MAX);
    // Dependencies are masked while a branch is outstanding; the branch stall already holds decode.
    dep_stall = I_DE_Valid && (src1_haz || src2_haz || dst_full) && (state_q != WAIT_RESOLVE);
    issue     = I_DE_Valid && !dep_stall && !br_stall_q;
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue && I_DE_DstValid) inc_vec[I_DE_Dst] = 1'b1;
    if (I_WB_Valid)             dec_vec[I_WB_Dst] = 1'b1;
  end

  always_comb begin
    sb_err = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = pend_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        pend_d[r] = pend_q[r] + CNT_W'(1);
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (pend_q[r] == '0) sb_err = 1'b1;
        else                 pend_d[r] = pend_q[r] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    sel_d   = 1'b0;
    pc_d    = pc_q;
    fsm_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue && I_DE_IsBranch) begin
          state_d = WAIT_RESOLVE;
          tmo_d   = '0;
        end
        if (I_MEM_BrResolve) fsm_err = 1'b1;
      end
      WAIT_RESOLVE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (I_MEM_BrResolve) begin
          sel_d   = I_MEM_BrTaken;
          if (I_MEM_BrTaken) pc_d = I_MEM_BrTarget;
          state_d = REDIRECT;
        end else if (tmo_q == TMO_W'(RESOLVE_TIMEOUT - 1)) begin
          fsm_err = 1'b1;
          state_d = IDLE;
        end
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    br_stall_d = (state_d == WAIT_RESOLVE);
    err_d      = err_q || sb_err || fsm_err;
  end

  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      br_stall_q <= 1'b0;
      sel_q      <= 1'b0;
      pc_q       <= '0;
      err_q      <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      br_stall_q <= br_stall_d;
      sel_q      <= sel_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
    end
  end

  assign O_DepStallSignal    = dep_stall;
  assign O_Issue             = issue;
  assign O_BranchStallSignal = br_stall_q;
  assign O_BranchAddrSelect  = sel_q;
  assign O_BranchPC          = pc_q;
  assign O_Error             = err_q;

endmodule

// File: tb/tb_stall_controller.sv
// Directed bench for stall_controller: scoreboard hazards, branch resolve/redirect, timeout, error and async reset.
module tb_stall_controller;

  logic        I_CLOCK, I_LOCK;
  logic        I_DE_Valid, I_DE_IsBranch;
  logic        I_DE_Src1Valid, I_DE_Src2Valid, I_DE_DstValid;
  logic [3:0]  I_DE_Src1, I_DE_Src2, I_DE_Dst;
  logic        I_WB_Valid;
  logic [3:0]  I_WB_Dst;
  logic        I_MEM_BrResolve, I_MEM_BrTaken;
  logic [15:0] I_MEM_BrTarget;
  logic        O_DepStallSignal, O_BranchStallSignal, O_BranchAddrSelect, O_Issue, O_Error;
  logic [15:0] O_BranchPC;

  int checks = 0;
  int errors = 0;

  stall_controller dut (
    .I_CLOCK(I_CLOCK), .I_LOCK(I_LOCK),
    .I_DE_Valid(I_DE_Valid), .I_DE_IsBranch(I_DE_IsBranch),
    .I_DE_Src1Valid(I_DE_Src1Valid), .I_DE_Src1(I_DE_Src1),
    .I_DE_Src2Valid(I_DE_Src2Valid), .I_DE_Src2(I_DE_Src2),
    .I_DE_DstValid(I_DE_DstValid), .I_DE_Dst(I_DE_Dst),
    .I_WB_Valid(I_WB_Valid), .I_WB_Dst(I_WB_Dst),
    .I_MEM_BrResolve(I_MEM_BrResolve), .I_MEM_BrTaken(I_MEM_BrTaken),
    .I_MEM_BrTarget(I_MEM_BrTarget),
    .O_DepStallSignal(O_DepStallSignal), .O_BranchStallSignal(O_BranchStallSignal),
    .O_BranchAddrSelect(O_BranchAddrSelect), .O_BranchPC(O_BranchPC),
    .O_Issue(O_Issue), .O_Error(O_Error)
  );

  initial begin
    I_CLOCK = 1'b0;
    forever #5 I_CLOCK = ~I_CLOCK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after posedge; the DUT commits on the following negedge.
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge I_CLOCK);
    #1;
  endtask

  task automatic clr();
    I_DE_Valid = 0; I_DE_IsBranch = 0;
    I_DE_Src1Valid = 0; I_DE_Src1 = 0;
    I_DE_Src2Valid = 0; I_DE_Src2 = 0;
    I_DE_DstValid = 0; I_DE_Dst = 0;
    I_WB_Valid = 0; I_WB_Dst = 0;
    I_MEM_BrResolve = 0; I_MEM_BrTaken = 0; I_MEM_BrTarget = 0;
  endtask

  initial begin
    clr();
    I_LOCK = 0;
    cyc(2);
    chk("rst_bstall", O_BranchStallSignal, 0);
    chk("rst_sel", O_BranchAddrSelect, 0);
    chk("rst_pc", O_BranchPC, 0);
    chk("rst_err", O_Error, 0);
    I_LOCK = 1;
    cyc(2);
    chk("idle_dep", O_DepStallSignal, 0);
    chk("idle_issue", O_Issue, 0);
    chk("idle_bstall", O_BranchStallSignal, 0);
    chk("idle_sel", O_BranchAddrSelect, 0);
    chk("idle_err", O_Error, 0);
    for (int r = 0; r < 16; r++) begin
      I_DE_Valid = 1; I_DE_Src1Valid = 1; I_DE_Src1 = 4'(r);
      #1 chk("pend_zero", O_DepStallSignal, 0);
      cyc();
    end
    clr(); cyc();

    // RAW on R3 until writeback retires it
    I_DE_Valid = 1; I_DE_DstValid = 1; I_DE_Dst = 3;
    #1 chk("r3_issue", O_Issue, 1);
    cyc(); clr();
    I_DE_Valid = 1; I_DE_Src1Valid = 1; I_DE_Src1 = 3;
    #1 chk("r3_dep", O_DepStallSignal, 1);
    chk("r3_noissue", O_Issue, 0);
    cyc();
    #1 chk("r3_dep_hold", O_DepStallSignal, 1);
    I_WB_Valid = 1; I_WB_Dst = 3;
    #1 chk("r3_dep_wb", O_DepStallSignal, 1);
    cyc();
    I_WB_Valid = 0;
    #1 chk("r3_release", O_DepStallSignal, 0);
    chk("r3_issue2", O_Issue, 1);
    cyc(); clr();

    // Taken branch resolved on the third stall cycle
    I_DE_Valid = 1; I_DE_IsBranch = 1;
    #1 chk("br_issue", O_Issue, 1);
    chk("br_nostall", O_BranchStallSignal, 0);
    cyc(); clr();
    I_DE_Valid = 1;
    #1 chk("br_stall1", O_BranchStallSignal, 1);
    chk("br_blocked", O_Issue, 0);
    cyc(); clr();
    #1 chk("br_stall2", O_BranchStallSignal, 1);
    cyc();
    I_MEM_BrResolve = 1; I_MEM_BrTaken = 1; I_MEM_BrTarget = 16'h0040;
    #1 chk("br_stall3", O_BranchStallSignal, 1);
    cyc(); clr();
    #1 chk("redir_sel", O_BranchAddrSelect, 1);
    chk("redir_pc", O_BranchPC, 16'h0040);
    chk("redir_nostall", O_BranchStallSignal, 0);
    cyc();
    #1 chk("post_sel", O_BranchAddrSelect, 0);
    chk("post_pc", O_BranchPC, 16'h0040);
    chk("post_stall", O_BranchStallSignal, 0);

    // Not-taken branch leaves the target alone
    I_DE_Valid = 1; I_DE_IsBranch = 1;
    cyc(); clr(); cyc();
    I_MEM_BrResolve = 1; I_MEM_BrTaken = 0; I_MEM_BrTarget = 16'h1234;
    #1 chk("nt_stall", O_BranchStallSignal, 1);
    cyc(); clr();
    #1 chk("nt_sel", O_BranchAddrSelect, 0);
    chk("nt_pc", O_BranchPC, 16'h0040);
    chk("nt_nostall", O_BranchStallSignal, 0);
    cyc();
    #1 chk("nt_idle_sel", O_BranchAddrSelect, 0);

    // Saturating writer count on R5
    I_DE_Valid = 1; I_DE_DstValid = 1; I_DE_Dst = 5;
    cyc(3);
    #1 chk("r5_full", O_DepStallSignal, 1);
    I_WB_Valid = 1; I_WB_Dst = 5;
    #1 chk("r5_full_wb", O_DepStallSignal, 1);
    cyc();
    #1 chk("r5_sim_issue", O_Issue, 1);
    cyc();
    I_WB_Valid = 0;
    #1 chk("r5_two", O_DepStallSignal, 0);
    cyc();
    #1 chk("r5_three", O_DepStallSignal, 1);
    clr(); I_WB_Valid = 1; I_WB_Dst = 5;
    cyc(3); clr();
    I_DE_Valid = 1; I_DE_Src2Valid = 1; I_DE_Src2 = 5;
    #1 chk("r5_drained", O_DepStallSignal, 0);
    chk("r5_no_err", O_Error, 0);
    cyc(); clr();

    // Resolve on the timeout cycle takes priority
    I_DE_Valid = 1; I_DE_IsBranch = 1;
    cyc(); clr(); cyc(7);
    I_MEM_BrResolve = 1; I_MEM_BrTaken = 1; I_MEM_BrTarget = 16'h0077;
    #1 chk("race_stall", O_BranchStallSignal, 1);
    cyc(); clr();
    #1 chk("race_sel", O_BranchAddrSelect, 1);
    chk("race_pc", O_BranchPC, 16'h0077);
    chk("race_err", O_Error, 0);
    cyc();

    // Timeout after eight unresolved cycles
    I_DE_Valid = 1; I_DE_IsBranch = 1;
    cyc(); clr();
    for (int i = 0; i < 8; i++) begin
      #1 chk("tmo_stall", O_BranchStallSignal, 1);
      cyc();
    end
    #1 chk("tmo_release", O_BranchStallSignal, 0);
    chk("tmo_err", O_Error, 1);
    chk("tmo_nosel", O_BranchAddrSelect, 0);
    chk("tmo_pc", O_BranchPC, 16'h0077);

    // Asynchronous reset while waiting with a pending write
    I_DE_Valid = 1; I_DE_DstValid = 1; I_DE_Dst = 7;
    cyc(); clr();
    I_DE_Valid = 1; I_DE_IsBranch = 1;
    cyc(); clr();
    #1 chk("mid_stall", O_BranchStallSignal, 1);
    I_LOCK = 0;
    #1 chk("mid_rst_stall", O_BranchStallSignal, 0);
    chk("mid_rst_pc", O_BranchPC, 0);
    chk("mid_rst_err", O_Error, 0);
    cyc(); I_LOCK = 1; cyc();
    I_DE_Valid = 1; I_DE_Src1Valid = 1; I_DE_Src1 = 7;
    #1 chk("mid_pend_clr", O_DepStallSignal, 0);
    cyc(); clr();

    // Stray resolve in IDLE
    I_MEM_BrResolve = 1; I_MEM_BrTaken = 1; I_MEM_BrTarget = 16'h0099;
    cyc(); clr();
    #1 chk("stray_err", O_Error, 1);
    chk("stray_sel", O_BranchAddrSelect, 0);
    I_LOCK = 0;
    #1 chk("rst2_err", O_Error, 0);
    cyc(); I_LOCK = 1; cyc();

    // Writeback underflow
    I_WB_Valid = 1; I_WB_Dst = 9;
    cyc(); clr();
    #1 chk("uf_err", O_Error, 1);
    I_DE_Valid = 1; I_DE_Src1Valid = 1; I_DE_Src1 = 9;
    #1 chk("uf_pend0", O_DepStallSignal, 0);
    cyc(); clr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
